// File: rtl/gpu_ext_req_seq.sv
// Data-side external access sequencer: queues pipeline loads/stores, issues them
// one at a time to the gateway, tracks completion and returns load results.
module gpu_ext_req_seq #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_dreg,
  output logic        external,
  output logic        progserv,
  output logic [23:0] gpu_addr,
  output logic [1:0]  msize,
  output logic        gpu_memw,
  output logic [31:0] gpu_din,
  input  logic        gate_active,
  input  logic        xld_ready,
  input  logic [31:0] load_data,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        ld_pending,
  output logic        bus_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic        write;
    logic [23:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [4:0]  dreg;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_WB
  } state_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_tmo_cnt;
  logic          r_bus_err;
  logic [23:0]   r_gpu_addr;
  logic [1:0]    r_msize;
  logic          r_gpu_memw;
  logic [31:0]   r_gpu_din;
  logic [4:0]    r_wb_reg;
  logic [31:0]   r_wb_data;

  req_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_issue;
  logic w_capture;
  logic w_timeout;
  logic w_ld_any;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = ce & req_valid & ~w_full;

  // NOTE: FIFO storage has no reset; r_count alone decides which slots hold live requests.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{write: req_write, addr: req_addr, size: req_size,
                           wdata: req_wdata, dreg: req_dreg};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (ce) begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset)   r_state <= S_IDLE;
    else if (ce) r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !gate_active) begin
          w_next  = S_ISSUE;
          w_issue = 1'b1;
        end
      end
      S_ISSUE:    w_next = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (gate_active) begin
          w_next = S_WAIT_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout = 1'b1;
          w_pop     = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (w_head.write) begin
          if (!gate_active) begin
            w_pop  = 1'b1;
            w_next = S_IDLE;
          end
        end else if (xld_ready) begin
          w_capture = 1'b1;
          w_pop     = 1'b1;
          w_next    = S_WB;
        end
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus fields are latched when the head is issued, so they stay put through the
  // gateway's address latch and keep their last values once the queue drains.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_tmo_cnt  <= '0;
      r_bus_err  <= 1'b0;
      r_gpu_addr <= '0;
      r_msize    <= '0;
      r_gpu_memw <= 1'b0;
      r_gpu_din  <= '0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
    end else if (ce) begin
      if (r_state == S_ISSUE) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT_ACT && !gate_active && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
      if (w_timeout) r_bus_err <= 1'b1;
      if (w_issue) begin
        r_gpu_addr <= w_head.addr;
        r_msize    <= w_head.size;
        r_gpu_memw <= w_head.write;
        r_gpu_din  <= w_head.wdata;
      end
      if (w_capture) begin
        r_wb_reg  <= w_head.dreg;
        r_wb_data <= load_data;
      end
    end
  end

  // The in-flight head is still a queue entry until it pops, so scanning live
  // entries covers both queued and in-flight loads.
  always_comb begin
    w_ld_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && !r_mem[r_rd_ptr + AW'(i)].write) w_ld_any = 1'b1;
    end
  end

  assign req_ready  = ~w_full;
  assign external   = (r_state == S_ISSUE);
  assign progserv   = 1'b0;
  assign gpu_addr   = r_gpu_addr;
  assign msize      = r_msize;
  assign gpu_memw   = r_gpu_memw;
  assign gpu_din    = r_gpu_din;
  assign wb_valid   = (r_state == S_WB);
  assign wb_reg     = r_wb_reg;
  assign wb_data    = r_wb_data;
  assign busy       = ~w_empty | (r_state != S_IDLE);
  assign ld_pending = w_ld_any;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_gpu_ext_req_seq.sv
// Self-checking bench for gpu_ext_req_seq: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_gpu_ext_req_seq;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset, ce, req_valid, req_write;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [4:0]  req_dreg;
  logic        req_ready, external, progserv, gpu_memw, wb_valid, busy, ld_pending, bus_err;
  logic [23:0] gpu_addr;
  logic [1:0]  msize;
  logic [31:0] gpu_din, wb_data, load_data;
  logic [4:0]  wb_reg;
  logic        gate_active, xld_ready;

  logic        gw_auto = 1'b0, gw_gate = 1'b0, gw_xld = 1'b0, gw_ld = 1'b0;
  logic [31:0] gw_data = '0;
  int          gw_cnt = 0;
  logic        man_gate = 1'b0, man_xld = 1'b0;
  logic [31:0] man_data = '0;

  assign gate_active = gw_auto ? gw_gate : man_gate;
  assign xld_ready   = gw_auto ? gw_xld  : man_xld;
  assign load_data   = gw_auto ? gw_data : man_data;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 1'b0;
  int wb_cnt = 0;
  logic [23:0] ext_log[$];

  always #5 clk = ~clk;

  gpu_ext_req_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_dreg(req_dreg),
    .external(external), .progserv(progserv), .gpu_addr(gpu_addr), .msize(msize),
    .gpu_memw(gpu_memw), .gpu_din(gpu_din), .gate_active(gate_active),
    .xld_ready(xld_ready), .load_data(load_data), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .ld_pending(ld_pending),
    .bus_err(bus_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted requests plus the phase of the head.
  typedef struct {
    bit        write;
    bit [23:0] addr;
    bit [1:0]  size;
    bit [31:0] wdata;
    bit [4:0]  dreg;
  } mreq_t;
  typedef enum {P_IDLE, P_ISSUE, P_ACT, P_DONE, P_WB} phase_t;

  mreq_t     mq[$];
  phase_t    m_phase = P_IDLE;
  int        m_wait = 0;
  bit [23:0] m_addr;
  bit [1:0]  m_size;
  bit        m_memw, m_err;
  bit [31:0] m_din, m_wbd;
  bit [4:0]  m_wbr;

  always @(posedge clk) begin : model
    bit do_pop, do_push;
    if (reset) begin
      mq.delete();
      m_phase = P_IDLE; m_wait = 0; m_err = 0;
      m_addr = 0; m_size = 0; m_memw = 0; m_din = 0; m_wbr = 0; m_wbd = 0;
    end else if (ce) begin
      do_push = req_valid && (mq.size() < DEPTH);
      do_pop  = 0;
      case (m_phase)
        P_IDLE: if (mq.size() != 0 && !gate_active) begin
          m_phase = P_ISSUE;
          m_addr = mq[0].addr; m_size = mq[0].size; m_memw = mq[0].write; m_din = mq[0].wdata;
        end
        P_ISSUE: begin m_wait = 0; m_phase = P_ACT; end
        P_ACT: begin
          if (gate_active) m_phase = P_DONE;
          else if (m_wait == TIMEOUT - 1) begin m_err = 1; do_pop = 1; m_phase = P_IDLE; end
          else m_wait++;
        end
        P_DONE: begin
          if (mq[0].write) begin
            if (!gate_active) begin do_pop = 1; m_phase = P_IDLE; end
          end else if (xld_ready) begin
            m_wbr = mq[0].dreg; m_wbd = load_data; do_pop = 1; m_phase = P_WB;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{write: req_write, addr: req_addr, size: req_size,
                                  wdata: req_wdata, dreg: req_dreg});
    end
  end

  function automatic bit exp_ld_pending();
    foreach (mq[i]) if (!mq[i].write) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_req_ready",  req_ready,  mq.size() < DEPTH);
      check("m_external",   external,   m_phase == P_ISSUE);
      check("m_progserv",   progserv,   0);
      check("m_gpu_addr",   gpu_addr,   m_addr);
      check("m_msize",      msize,      m_size);
      check("m_gpu_memw",   gpu_memw,   m_memw);
      check("m_gpu_din",    gpu_din,    m_din);
      check("m_wb_valid",   wb_valid,   m_phase == P_WB);
      check("m_wb_reg",     wb_reg,     m_wbr);
      check("m_wb_data",    wb_data,    m_wbd);
      check("m_busy",       busy,       mq.size() != 0 || m_phase != P_IDLE);
      check("m_ld_pending", ld_pending, exp_ld_pending());
      check("m_bus_err",    bus_err,    m_err);
      if (external) ext_log.push_back(gpu_addr);
      if (wb_valid) wb_cnt++;
    end
  end

  // Simple gateway: on external, hold gate_active three ce-cycles; loads get
  // xld_ready on the last of them.
  always @(negedge clk) begin
    if (!gw_auto) begin
      gw_cnt = 0; gw_gate = 0; gw_xld = 0;
    end else if (gw_cnt == 0 && external) begin
      gw_gate = 1; gw_cnt = 3; gw_ld = !gpu_memw;
    end else if (gw_cnt > 0) begin
      gw_cnt--;
      gw_xld = (gw_cnt == 1) && gw_ld;
      if (gw_cnt == 0) gw_gate = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit w, input bit [23:0] a, input bit [1:0] s,
                      input bit [31:0] d, input bit [4:0] r);
    bit rdy;
    int b = 0;
    req_valid = 1; req_write = w; req_addr = a; req_size = s; req_wdata = d; req_dreg = r;
    do begin
      rdy = req_ready;
      @(negedge clk);
      b++;
    end while (!rdy && b < 50);
    check("push_accept", rdy, 1);
    req_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    int b = 0;
    while (busy && b < 100) begin @(negedge clk); b++; end
    check(nm, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int base, wbb;
  bit [23:0] t3_addr [3];

  initial begin
    reset = 1; ce = 1; req_valid = 0; req_write = 0; req_addr = 0;
    req_size = 0; req_wdata = 0; req_dreg = 0;
    tick(3);
    cmp_en = 1;
    check("rst_external", external, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_gpu_addr", gpu_addr, 0);
    check("rst_ld_pending", ld_pending, 0);
    reset = 0;
    tick();

    // Store byte
    wbb = wb_cnt;
    push(1, 24'hF03000, 2'd0, 32'h0000_00A5, 5'd0);
    check("t1_ext_early", external, 0);
    tick();
    check("t1_external", external, 1);
    check("t1_gpu_addr", gpu_addr, 24'hF03000);
    check("t1_msize", msize, 0);
    check("t1_gpu_memw", gpu_memw, 1);
    check("t1_gpu_din", gpu_din, 32'hA5);
    man_gate = 1;
    tick(3);
    check("t1_busy_active", busy, 1);
    man_gate = 0;
    tick();
    check("t1_busy_done", busy, 0);
    check("t1_no_wb", wb_cnt, wbb);

    // Load long
    push(0, 24'h001234, 2'd2, 32'h0, 5'd7);
    check("t2_ld_pending", ld_pending, 1);
    tick();
    check("t2_external", external, 1);
    check("t2_gpu_memw", gpu_memw, 0);
    man_gate = 1;
    tick(2);
    man_xld = 1; man_data = 32'hDEADBEEF;
    tick();
    check("t2_wb_valid", wb_valid, 1);
    check("t2_wb_reg", wb_reg, 7);
    check("t2_wb_data", wb_data, 32'hDEADBEEF);
    check("t2_ld_pending_wb", ld_pending, 0);
    man_xld = 0; man_gate = 0;
    tick();
    check("t2_wb_one_cycle", wb_valid, 0);
    check("t2_idle", busy, 0);

    // Back-to-back A, B, C
    gw_auto = 1; gw_data = 32'h0BADF00D;
    t3_addr[0] = 24'h000100; t3_addr[1] = 24'h000200; t3_addr[2] = 24'h000300;
    base = ext_log.size();
    push(1, t3_addr[0], 2'd1, 32'h1111, 5'd0);
    push(0, t3_addr[1], 2'd2, 32'h0, 5'd3);
    check("t3_full", req_ready, 0);
    push(1, t3_addr[2], 2'd0, 32'h33, 5'd0);
    wait_idle("t3_idle");
    check("t3_n_issue", ext_log.size() - base, 3);
    if (ext_log.size() >= base + 3)
      for (int i = 0; i < 3; i++) check("t3_order", ext_log[base + i], t3_addr[i]);
    check("t3_wb_reg", wb_reg, 3);
    check("t3_wb_data", wb_data, 32'h0BADF00D);
    gw_auto = 0;
    tick();

    // Gateway busy with another master
    man_gate = 1;
    base = ext_log.size();
    push(1, 24'h000400, 2'd0, 32'h44, 5'd0);
    tick(4);
    check("t4_held", ext_log.size() - base, 0);
    check("t4_busy", busy, 1);
    man_gate = 0;
    tick();
    check("t4_external", external, 1);
    man_gate = 1;
    tick(2);
    man_gate = 0;
    wait_idle("t4_idle");

    // Timeout
    wbb = wb_cnt;
    push(1, 24'h000500, 2'd0, 32'h55, 5'd0);
    tick();
    check("t5_external", external, 1);
    tick(4);
    check("t5_err_early", bus_err, 0);
    check("t5_busy_wait", busy, 1);
    tick();
    check("t5_bus_err", bus_err, 1);
    check("t5_dropped", busy, 0);
    check("t5_no_wb", wb_cnt, wbb);
    gw_auto = 1; gw_data = 32'hCAFE0001;
    push(0, 24'h000600, 2'd2, 32'h0, 5'd12);
    wait_idle("t5_next_idle");
    check("t5_next_wb", wb_cnt, wbb + 1);
    check("t5_next_wb_data", wb_data, 32'hCAFE0001);
    check("t5_next_wb_reg", wb_reg, 12);
    check("t5_err_sticky", bus_err, 1);
    gw_auto = 0;
    tick();

    // Reset mid-load with two entries queued
    push(0, 24'h000700, 2'd2, 32'h0, 5'd9);
    tick();
    check("t6_external", external, 1);
    man_gate = 1;
    push(1, 24'h000800, 2'd1, 32'h88, 5'd0);
    tick();
    check("t6_full", req_ready, 0);
    check("t6_ld_pending", ld_pending, 1);
    reset = 1;
    tick();
    check("t6_rst_external", external, 0);
    check("t6_rst_wb_valid", wb_valid, 0);
    check("t6_rst_bus_err", bus_err, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_ready", req_ready, 1);
    check("t6_rst_ld_pending", ld_pending, 0);
    check("t6_rst_gpu_addr", gpu_addr, 0);
    check("t6_rst_wb_data", wb_data, 0);
    reset = 0; man_gate = 0;
    tick();

    // ce held low mid-WAIT_ACT
    push(1, 24'h000900, 2'd0, 32'h99, 5'd0);
    tick();
    check("t6_ce_external", external, 1);
    tick(2);
    ce = 0; man_gate = 1;
    req_valid = 1; req_write = 0; req_addr = 24'h000A00; req_dreg = 5'd1;
    tick(5);
    check("t6_ce_busy", busy, 1);
    check("t6_ce_no_push", ld_pending, 0);
    check("t6_ce_err", bus_err, 0);
    req_valid = 0; man_gate = 0; ce = 1;
    tick(2);
    check("t6_ce_err_frozen", bus_err, 0);
    tick();
    check("t6_ce_err_resume", bus_err, 1);
    check("t6_ce_idle", busy, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ce        = ($urandom_range(0, 9) < 8);
      reset     = ($urandom_range(0, 399) == 0);
      req_valid = $urandom_range(0, 1);
      req_write = $urandom_range(0, 1);
      req_addr  = 24'($urandom);
      req_size  = 2'($urandom_range(0, 3));
      req_wdata = $urandom;
      req_dreg  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 3) man_gate = !man_gate;
      man_xld  = ($urandom_range(0, 3) == 0);
      man_data = $urandom;
      tick();
    end
    reset = 0; ce = 1; req_valid = 0; man_gate = 0; man_xld = 0;
    tick(20);
    check("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
